// File: rtl/eq.sv
// Registered WIDTH-bit equality comparator: zero flag, per-bit difference mask and
// lowest differing bit index, one cycle after each accepted compare. Optional EQ_MASK_EN adds compare_mask.
module eq #(
  parameter int WIDTH = 20,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] register_A,
  input  logic [WIDTH-1:0] register_B,
`ifdef EQ_MASK_EN
  input  logic [WIDTH-1:0] compare_mask,
`endif
  output logic             zero_flag,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff_mask,
  output logic [IDX_W-1:0] first_diff_idx
);

  // Priority encoder: scanning from the MSB down lets the lowest set bit win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] mask_p0;
  logic [WIDTH-1:0] diff_p0;
  logic             zero_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             vld_p0;

`ifdef EQ_MASK_EN
  assign mask_p0 = compare_mask;
`else
  assign mask_p0 = '1;
`endif

  assign vld_p0  = in_valid;
  assign diff_p0 = (register_A ^ register_B) & mask_p0;
  assign zero_p0 = ~|diff_p0;
  assign idx_p0  = lowest_set(diff_p0);

  // ---- p0 -> p1 register boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag      <= 1'b1;
      out_valid      <= 1'b0;
      diff_mask      <= '0;
      first_diff_idx <= '0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        zero_flag      <= zero_p0;
        diff_mask      <= diff_p0;
        first_diff_idx <= idx_p0;
      end
    end
  end

endmodule

// File: tb/tb_eq.sv
// Self-checking bench for eq: scoreboard of expected compare results, checked one cycle later.
// Define EQ_MASK_EN for both files to exercise the compare_mask variant.
module tb_eq;
  localparam int WIDTH = 20;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] register_A;
  logic [WIDTH-1:0] register_B;
  logic [WIDTH-1:0] compare_mask;
  logic             zero_flag;
  logic             out_valid;
  logic [WIDTH-1:0] diff_mask;
  logic [IDX_W-1:0] first_diff_idx;

  eq #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .register_A     (register_A),
    .register_B     (register_B),
`ifdef EQ_MASK_EN
    .compare_mask   (compare_mask),
`endif
    .zero_flag      (zero_flag),
    .out_valid      (out_valid),
    .diff_mask      (diff_mask),
    .first_diff_idx (first_diff_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             z;
    logic [WIDTH-1:0] d;
    logic [IDX_W-1:0] i;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic             got;
  logic             hz;
  logic [WIDTH-1:0] hd;
  logic [IDX_W-1:0] hi;

  // Drive one cycle of inputs; an accepted compare queues its expected result.
  task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic v,
                       input logic ez, input logic [WIDTH-1:0] ed, input logic [IDX_W-1:0] ei);
    exp_t e;
    register_A = a;
    register_B = b;
    in_valid   = v;
    if (v && rst_n) begin
      e.z = ez; e.d = ed; e.i = ei;
      sb.push_back(e);
    end
  endtask

  // Advance one edge and pop whatever result should now be visible.
  task automatic tick_pop();
    exp_t e;
    @(posedge clk);
    #1;
    got = 1'b0;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = 1'b1;
      hz  = e.z; hd = e.d; hi = e.i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    compare_mask = '1;
    hz = 1'b1; hd = '0; hi = '0;
    apply(20'h00001, 20'h00000, 1'b1, 1'b0, 20'h0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      tick_pop();
      n_checks++;
      if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b0, 1'b1, 20'h0, 5'd0}) begin
        n_fail++;
        $display("FAIL reset[%0d] got v=%0b z=%0b d=%h i=%0d want v=0 z=1 d=00000 i=0",
                 k, out_valid, zero_flag, diff_mask, first_diff_idx);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_equal();
    apply(20'hABCDE, 20'hABCDE, 1'b1, 1'b1, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL equal got v=%0b z=%0b d=%h i=%0d want v=1 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    apply(20'h11111, 20'h22222, 1'b0, 1'b0, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b0, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL equal_idle got v=%0b z=%0b d=%h i=%0d want v=0 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
  endtask

  task automatic test_single_bit();
    apply(20'hABCDE, 20'hABCDF, 1'b1, 1'b0, 20'h00001, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b0, 20'h00001, 5'd0}) begin
      n_fail++;
      $display("FAIL bit0 got v=%0b z=%0b d=%h i=%0d want v=1 z=0 d=00001 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    apply(20'h80000, 20'h00000, 1'b1, 1'b0, 20'h80000, 5'd19);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b0, 20'h80000, 5'd19}) begin
      n_fail++;
      $display("FAIL bit19 got v=%0b z=%0b d=%h i=%0d want v=1 z=0 d=80000 i=19",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    apply(20'h0, 20'h0, 1'b0, 1'b0, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b0, 1'b0, 20'h80000, 5'd19}) begin
      n_fail++;
      $display("FAIL bit19_hold got v=%0b z=%0b d=%h i=%0d want v=0 z=0 d=80000 i=19",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
  endtask

  task automatic test_back_to_back();
    apply(20'hFFFFF, 20'h0FFF0, 1'b1, 1'b0, 20'hF000F, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b0, 20'hF000F, 5'd0}) begin
      n_fail++;
      $display("FAIL b2b_first got v=%0b z=%0b d=%h i=%0d want v=1 z=0 d=f000f i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    apply(20'h12345, 20'h12345, 1'b1, 1'b1, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL b2b_second got v=%0b z=%0b d=%h i=%0d want v=1 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    apply(20'h0, 20'h0, 1'b0, 1'b0, 20'h0, 5'd0);
    tick_pop();
  endtask

  task automatic test_reset_mid();
    apply(20'h00001, 20'h00002, 1'b1, 1'b0, 20'h00003, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b0, 20'h00003, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_pre got v=%0b z=%0b d=%h i=%0d want v=1 z=0 d=00003 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    rst_n = 1'b0;
    hz = 1'b1; hd = '0; hi = '0;
    apply(20'h00004, 20'h00010, 1'b1, 1'b0, 20'h00014, 5'd2);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b0, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_reset got v=%0b z=%0b d=%h i=%0d want v=0 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b0, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_after got v=%0b z=%0b d=%h i=%0d want v=0 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
  endtask

  // Random stream with occasional idles; expected index from the isolated lowest set bit.
  task automatic test_random();
    logic [WIDTH-1:0] a, b, d, lsb;
    logic             v;
    for (int k = 0; k < 60; k++) begin
      a = WIDTH'($urandom);
      b = (k % 4 == 0) ? a : (a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0)) ^ WIDTH'($urandom & 32'h000F0000));
      v = ($urandom_range(4, 0) != 0);
      d   = (a ^ b) & compare_mask;
      lsb = d & (~d + 1'b1);
      apply(a, b, v, (d == '0), d, IDX_W'($clog2(lsb)));
      tick_pop();
      n_checks++;
      if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {got, hz, hd, hi}) begin
        n_fail++;
        $display("FAIL random[%0d] got v=%0b z=%0b d=%h i=%0d want v=%0b z=%0b d=%h i=%0d",
                 k, out_valid, zero_flag, diff_mask, first_diff_idx, got, hz, hd, hi);
      end
    end
    apply(20'h0, 20'h0, 1'b0, 1'b0, 20'h0, 5'd0);
    tick_pop();
  endtask

`ifdef EQ_MASK_EN
  task automatic test_mask();
    compare_mask = 20'hFFFF0;
    apply(20'hABCDE, 20'hABCD0, 1'b1, 1'b1, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL mask_low got v=%0b z=%0b d=%h i=%0d want v=1 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    compare_mask = 20'hFFFFF;
    apply(20'hABCDE, 20'hABCD0, 1'b1, 1'b0, 20'h0000E, 5'd1);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b0, 20'h0000E, 5'd1}) begin
      n_fail++;
      $display("FAIL mask_full got v=%0b z=%0b d=%h i=%0d want v=1 z=0 d=0000e i=1",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    compare_mask = 20'h00000;
    apply(20'hFFFFF, 20'h00000, 1'b1, 1'b1, 20'h0, 5'd0);
    tick_pop();
    n_checks++;
    if ({out_valid, zero_flag, diff_mask, first_diff_idx} !== {1'b1, 1'b1, 20'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL mask_zero got v=%0b z=%0b d=%h i=%0d want v=1 z=1 d=00000 i=0",
               out_valid, zero_flag, diff_mask, first_diff_idx);
    end
    compare_mask = 20'hF0F0F;
    test_random();
    compare_mask = '1;
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    register_A   = '0;
    register_B   = '0;
    compare_mask = '1;
    got = 1'b0;
    hz = 1'b1; hd = '0; hi = '0;
    #2;
    test_reset();
    test_equal();
    test_single_bit();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef EQ_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eq.md
Name: eq

Overview:
- Registered 20-bit equality comparator for the ALU comparison group.
- Compares register_A against register_B each accepted cycle.
- Raises zero_flag when the operands are equal, matching ALU flag semantics where A-B=0.
- Also reports which bits differ and the index of the lowest differing bit, for branch and debug logic.

Parameters:
- WIDTH, 20: operand width in bits; must be at least 2.
- IDX_W, $clog2(WIDTH): width of the first_diff_idx output (5 for the default).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands valid this cycle; a compare is accepted only when high.
- register_A  input  WIDTH  operand A.
- register_B  input  WIDTH  operand B.
- zero_flag  output  1  registered; 1 when the last accepted A equals B.
- out_valid  output  1  registered; 1 for exactly one cycle after each accepted compare.
- diff_mask  output  WIDTH  registered; register_A XOR register_B of the last accepted compare.
- first_diff_idx  output  IDX_W  registered; index of the lowest set bit of diff_mask, or 0 when there is none.

Behaviour:
- Reset, on a clk edge with rst_n=0:
  - zero_flag=1 (an empty compare counts as equal), out_valid=0, diff_mask=0, first_diff_idx=0.
  - Reset overrides in_valid in the same cycle; a compare presented during reset is dropped.
- Accepted cycle (rst_n=1, in_valid=1) updates on the next edge:
  - diff_mask <= A ^ B.
  - zero_flag <= (A ^ B)==0.
  - first_diff_idx <= lowest i with A[i]!=B[i], else 0.
  - out_valid <= 1.
- Latency is exactly one cycle from inputs to registered outputs. There is no backpressure, so a new compare can be accepted every cycle.
- Idle cycle (in_valid=0): out_valid <= 0; zero_flag, diff_mask and first_diff_idx hold their last values.
- Comparison is unsigned and bitwise only; no sign handling and no X-propagation guarantees.
- first_diff_idx is a priority encoder with the LSB having highest priority. It is combinationally derived from A^B before the register. zero_flag=1 distinguishes the "no difference" case from "difference at bit 0".
- Back-to-back compares: each accepted cycle produces its own out_valid pulse, and the outputs reflect the most recent compare.

Optional Feature:
- Macro EQ_MASK_EN.
- When defined:
  - Adds input compare_mask [WIDTH-1:0], sampled with in_valid.
  - Bits with compare_mask[i]=0 are ignored: diff_mask <= (A ^ B) & compare_mask.
  - zero_flag and first_diff_idx are computed from the masked value.
  - An all-zero mask yields zero_flag=1.
- When undefined: the port is absent and all WIDTH bits are compared, equivalent to a mask of all ones.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=20'h00001, B=0 -> zero_flag=1, out_valid=0, diff_mask=0, first_diff_idx=0.
- Equal operands: A=B=20'hABCDE, in_valid=1 for one cycle -> next cycle zero_flag=1, out_valid=1, diff_mask=0, first_diff_idx=0; following idle cycle out_valid=0 with zero_flag still 1.
- Single-bit difference: A=20'hABCDE, B=20'hABCDF -> zero_flag=0, diff_mask=20'h00001, first_diff_idx=0. Then A=20'h80000, B=0 -> diff_mask=20'h80000, first_diff_idx=19.
- Multi-bit and back-to-back: cycle n A=20'hFFFFF, B=20'h0FFF0; cycle n+1 A=B=20'h12345 -> cycle n+1 outputs zero_flag=0, diff_mask=20'hF000F, first_diff_idx=0, out_valid=1; cycle n+2 zero_flag=1, out_valid=1.
- Reset mid-stream: accepted compare A=1, B=2, then rst_n=0 on the next edge with in_valid=1 -> outputs return to reset values, and no out_valid pulse occurs for the dropped compare.
- EQ_MASK_EN: A=20'hABCDE, B=20'hABCD0, mask=20'hFFFF0 -> zero_flag=1, diff_mask=0. Same operands with mask=20'hFFFFF -> zero_flag=0, diff_mask=20'h0000E, first_diff_idx=1.
